// File: rtl/pwm_tone_pkg.sv
// Shared defaults, slot state encoding and width helpers for the PWM tone mixer.
package pwm_tone_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DIV_W  = 12;
    localparam int DEF_VOL_W  = 3;
    localparam int DEF_PWM_W  = 8;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    // Wide enough for NUM_CH full-volume channels summed without overflow.
    function automatic int mix_width(input int num_ch, input int vol_w);
        return vol_w + $clog2(num_ch) + 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_tone_mixer_if.sv
// Configuration write channel of the tone mixer: valid/ready plus channel, divider and volume.
interface pwm_tone_mixer_if
    import pwm_tone_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W,
    parameter int VOL_W  = DEF_VOL_W
) ();

    localparam int CH_W = ch_width(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [VOL_W-1:0] cfg_vol;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_vol,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_vol,
        output cfg_ready
    );

endinterface

// File: rtl/tone_channel.sv
// One square-wave tone voice: divider/volume registers, phase counter and square bit.
module tone_channel
    import pwm_tone_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int VOL_W = DEF_VOL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             apply,
    input  logic             enable,
    input  logic [DIV_W-1:0] new_div,
    input  logic [VOL_W-1:0] new_vol,
    output logic [VOL_W-1:0] contrib
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [VOL_W-1:0] vol;
    logic [VOL_W-1:0] vol_next;
    logic             sq;
    logic             sq_next;

    // A config apply restarts the phase but keeps the square bit, so the tone does not click.
    always_comb begin
        div_next = div;
        vol_next = vol;
        cnt_next = cnt;
        sq_next  = sq;
        if (apply) begin
            div_next = new_div;
            vol_next = new_vol;
            cnt_next = '0;
        end else if (tick) begin
            if (div == '0) begin
                cnt_next = '0;
                sq_next  = 1'b0;
            end else if (cnt == div - DIV_W'(1)) begin
                cnt_next = '0;
                sq_next  = ~sq;
            end else begin
                cnt_next = cnt + DIV_W'(1);
            end
        end
        contrib = (sq_next && enable) ? vol_next : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            vol <= '0;
            cnt <= '0;
            sq  <= 1'b0;
        end else begin
            div <= div_next;
            vol <= vol_next;
            cnt <= cnt_next;
            sq  <= sq_next;
        end
    end

endmodule

// File: rtl/pwm_tone_mixer.sv
// Multi-channel square-tone mixer: single-slot config buffer, saturating mix and PWM output stage.
module pwm_tone_mixer
    import pwm_tone_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W,
    parameter int VOL_W  = DEF_VOL_W,
    parameter int PWM_W  = DEF_PWM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NUM_CH-1:0] ch_enable,
    pwm_tone_mixer_if.slave   cfg,
    output logic [PWM_W-1:0]  sample_out,
    output logic              sample_valid,
    output logic              pwm_out
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int MIX_W = mix_width(NUM_CH, VOL_W);
    localparam int CMP_W = (MIX_W > PWM_W) ? MIX_W : PWM_W;
    localparam logic [CMP_W-1:0] SAT_MAX = (CMP_W'(1) << PWM_W) - CMP_W'(1);

    slot_state_t      slot_state;
    slot_state_t      slot_next;
    logic             slot_free;
    logic             accept;
    logic             apply;
    logic [CH_W-1:0]  pend_ch;
    logic [DIV_W-1:0] pend_div;
    logic [VOL_W-1:0] pend_vol;

    logic [NUM_CH-1:0][VOL_W-1:0] contrib;
    logic [MIX_W-1:0] mix;
    logic [PWM_W-1:0] mix_sat;
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_state <= SLOT_EMPTY;
            pend_ch    <= '0;
            pend_div   <= '0;
            pend_vol   <= '0;
        end else begin
            slot_state <= slot_next;
            if (accept) begin
                pend_ch  <= cfg.cfg_ch;
                pend_div <= cfg.cfg_div;
                pend_vol <= cfg.cfg_vol;
            end
        end
    end

    // Only a registered-full slot is applied, so a write landing on a tick waits for the next one.
    always_comb begin
        slot_next = slot_state;
        slot_free = 1'b0;
        apply     = 1'b0;
        case (slot_state)
            SLOT_EMPTY: begin
                slot_free = 1'b1;
                if (cfg.cfg_valid) slot_next = SLOT_FULL;
            end
            SLOT_FULL: begin
                if (tick) begin
                    apply     = 1'b1;
                    slot_next = SLOT_EMPTY;
                end
            end
            default: slot_next = SLOT_EMPTY;
        endcase
    end

    assign accept        = cfg.cfg_valid && slot_free;
    assign cfg.cfg_ready = slot_free;

    // Out-of-range channel numbers match no instance and are therefore dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_apply;
        assign ch_apply = apply && (pend_ch == CH_W'(i));

        tone_channel #(
            .DIV_W (DIV_W),
            .VOL_W (VOL_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .apply   (ch_apply),
            .enable  (ch_enable[i]),
            .new_div (pend_div),
            .new_vol (pend_vol),
            .contrib (contrib[i])
        );
    end

    always_comb begin
        mix     = '0;
        mix_sat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix = mix + MIX_W'(contrib[i]);
        end
        if (CMP_W'(mix) > SAT_MAX) mix_sat = '1;
        else                       mix_sat = PWM_W'(mix);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= tick;
            if (tick) sample_out <= mix_sat;
        end
    end

    // Duty is only reloaded at the period boundary so a period never mixes two duty values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (pwm_cnt == '1) duty <= sample_out;
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_pwm_tone_mixer.sv
// Two mixer instances (4ch/8-bit PWM and 3ch/4-bit PWM) driven in lockstep and compared to a tick-level model.
module tb_pwm_tone_mixer;
    import pwm_tone_pkg::*;

    localparam int NA    = 4;
    localparam int NB    = 3;
    localparam int DIV_W = 12;
    localparam int VOL_W = 3;
    localparam int PA    = 8;
    localparam int PB    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [NA-1:0] ch_enable;
    logic [PA-1:0] sample_a;
    logic [PB-1:0] sample_b;
    logic          sv_a, sv_b, pwm_a, pwm_b;

    pwm_tone_mixer_if #(.NUM_CH(NA), .DIV_W(DIV_W), .VOL_W(VOL_W)) if_a ();
    pwm_tone_mixer_if #(.NUM_CH(NB), .DIV_W(DIV_W), .VOL_W(VOL_W)) if_b ();

    always #5 clk = ~clk;

    pwm_tone_mixer #(.NUM_CH(NA), .DIV_W(DIV_W), .VOL_W(VOL_W), .PWM_W(PA)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .ch_enable(ch_enable), .cfg(if_a.slave),
        .sample_out(sample_a), .sample_valid(sv_a), .pwm_out(pwm_a)
    );

    pwm_tone_mixer #(.NUM_CH(NB), .DIV_W(DIV_W), .VOL_W(VOL_W), .PWM_W(PB)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .ch_enable(ch_enable[NB-1:0]), .cfg(if_b.slave),
        .sample_out(sample_b), .sample_valid(sv_b), .pwm_out(pwm_b)
    );

    int checks = 0;
    int errors = 0;

    int    cur_valid, cur_ch, cur_div, cur_vol;
    int    tick_mode, tick_period, tick_cnt;
    bit    collect;
    int    got[$];

    // Reference state: each channel remembers its square bit at apply time and the ticks since.
    int    m_div[2][NA], m_vol[2][NA], m_sq0[2][NA], m_n[2][NA];
    bit    m_full[2];
    int    m_pch[2], m_pdiv[2], m_pvol[2];
    int    m_sample[2], m_k[2], m_duty[2];
    bit    m_svalid[2], m_pwm[2];
    int    numch[2]  = '{NA, NB};
    int    smax[2]   = '{255, 15};
    int    period[2] = '{256, 16};
    string sfx[2]    = '{"a", "b"};

    task automatic check_output(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sq_of(input int d, input int c);
        if (m_div[d][c] == 0) return (m_n[d][c] == 0) ? m_sq0[d][c] : 0;
        return m_sq0[d][c] ^ ((m_n[d][c] / m_div[d][c]) & 1);
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int c = 0; c < NA; c++) begin
                    m_div[d][c] = 0; m_vol[d][c] = 0; m_sq0[d][c] = 0; m_n[d][c] = 0;
                end
                m_full[d] = 0; m_sample[d] = 0; m_svalid[d] = 0;
                m_k[d] = 0; m_duty[d] = 0; m_pwm[d] = 0;
            end else begin
                int old_sample = m_sample[d];
                int c0 = m_k[d] % period[d];
                bit acc = (cur_valid != 0) && !m_full[d];
                if (tick) begin
                    int mix = 0;
                    for (int c = 0; c < numch[d]; c++) begin
                        if (m_full[d] && m_pch[d] == c) begin
                            m_sq0[d][c] = sq_of(d, c);
                            m_n[d][c]   = 0;
                            m_div[d][c] = m_pdiv[d];
                            m_vol[d][c] = m_pvol[d];
                        end else begin
                            m_n[d][c]++;
                        end
                    end
                    m_full[d] = 0;
                    for (int c = 0; c < numch[d]; c++)
                        if (ch_enable[c] && sq_of(d, c) != 0) mix += m_vol[d][c];
                    m_sample[d] = (mix > smax[d]) ? smax[d] : mix;
                    m_svalid[d] = 1;
                end else begin
                    m_svalid[d] = 0;
                end
                if (acc) begin
                    m_full[d] = 1;
                    m_pch[d]  = cur_ch & 3;
                    m_pdiv[d] = cur_div & 12'hFFF;
                    m_pvol[d] = cur_vol & 7;
                end
                m_pwm[d] = (c0 < m_duty[d]);
                if (c0 == period[d] - 1) m_duty[d] = old_sample;
                m_k[d]++;
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare all outputs #1 later.
    task automatic apply_stimulus();
        if (tick_mode == 1) begin
            tick = (tick_cnt % tick_period == 0);
            tick_cnt++;
        end else if (tick_mode == 2) begin
            tick = ($urandom_range(0, 3) == 0);
        end
        if_a.cfg_valid = 1'(cur_valid); if_b.cfg_valid = 1'(cur_valid);
        if_a.cfg_ch    = 2'(cur_ch);    if_b.cfg_ch    = 2'(cur_ch);
        if_a.cfg_div   = 12'(cur_div);  if_b.cfg_div   = 12'(cur_div);
        if_a.cfg_vol   = 3'(cur_vol);   if_b.cfg_vol   = 3'(cur_vol);
        @(posedge clk);
        #1;
        model_edge();
        for (int d = 0; d < 2; d++) begin
            check_output({"ready_", sfx[d]},  int'(d == 0 ? if_a.cfg_ready : if_b.cfg_ready), int'(!m_full[d]));
            check_output({"sample_", sfx[d]}, (d == 0) ? int'(sample_a) : int'(sample_b), m_sample[d]);
            check_output({"svalid_", sfx[d]}, int'(d == 0 ? sv_a : sv_b), int'(m_svalid[d]));
            check_output({"pwm_", sfx[d]},    int'(d == 0 ? pwm_a : pwm_b), int'(m_pwm[d]));
        end
        if (collect && sv_a) got.push_back(int'(sample_a));
    endtask

    task automatic cfg_write(input int ch, input int dv, input int vl, output int waited);
        bit acc;
        cur_valid = 1; cur_ch = ch; cur_div = dv; cur_vol = vl;
        waited = 0;
        do begin
            acc = !m_full[0];
            apply_stimulus();
            waited++;
        end while (!acc && waited < 64);
        if (!acc) check_output("cfg_accept_timeout", 0, 1);
        cur_valid = 0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        apply_stimulus();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus();
        apply_stimulus();
        rst = 1'b0;
    endtask

    initial begin
        int w;
        int max_a, max_b;
        int exp_tone[8] = '{0, 0, 7, 7, 0, 0, 7, 7};

        rst = 1'b1; tick = 1'b0; ch_enable = '1;
        cur_valid = 0; cur_ch = 0; cur_div = 0; cur_vol = 0;
        tick_mode = 0; tick_period = 4; tick_cnt = 1; collect = 0;
        do_reset();

        // Single tone ch0 div=2 vol=7, tick every 4 clocks.
        cfg_write(0, 2, 7, w);
        collect = 1; tick_mode = 1; tick_period = 4; tick_cnt = 1;
        for (int i = 0; i < 48; i++) apply_stimulus();
        collect = 0; tick_mode = 0; tick = 1'b0;
        check_output("tone_count", int'(got.size() >= 8), 1);
        if (got.size() >= 8)
            for (int i = 0; i < 8; i++) check_output("tone_seq", got[i], exp_tone[i]);

        // Back-to-back writes: the second stalls until the first is applied.
        cfg_write(1, 3, 5, w);
        check_output("first_write_immediate", w, 1);
        tick_mode = 1; tick_period = 5; tick_cnt = 1;
        cfg_write(2, 1, 4, w);
        check_output("stall_seen", int'(w > 1), 1);
        tick_mode = 0; tick = 1'b0;
        pulse_tick();

        // All channels div=1 vol=7, applied two ticks apart so their phases line up.
        do_reset();
        for (int c = 0; c < NA; c++) begin
            cfg_write(c, 1, 7, w);
            pulse_tick();
            pulse_tick();
        end
        max_a = 0; max_b = 0;
        for (int i = 0; i < 8; i++) begin
            pulse_tick();
            if (int'(sample_a) > max_a) max_a = int'(sample_a);
            if (int'(sample_b) > max_b) max_b = int'(sample_b);
        end
        check_output("mix_full_a", max_a, 28);
        check_output("mix_sat_b", max_b, 15);

        // Reset with the slot full, a tick and a write all present in the same cycle.
        cfg_write(1, 2, 3, w);
        rst = 1'b1; cur_valid = 1; tick = 1'b1;
        apply_stimulus();
        rst = 1'b0; cur_valid = 0; tick = 1'b0;
        check_output("rst_ready_a", int'(if_a.cfg_ready), 1);
        check_output("rst_sample_a", int'(sample_a), 0);
        pulse_tick();
        apply_stimulus();
        check_output("post_rst_sample_a", int'(sample_a), 0);
        check_output("post_rst_sample_b", int'(sample_b), 0);

        // Channel 3 is out of range for the 3-channel instance.
        cfg_write(0, 2, 7, w);
        pulse_tick();
        cfg_write(3, 1, 5, w);
        pulse_tick();
        apply_stimulus();
        check_output("oor_ready_b", int'(if_b.cfg_ready), 1);

        // Random traffic with occasional mutes, long dividers and resets.
        tick_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            cur_valid = ($urandom_range(0, 2) == 0) ? 1 : 0;
            cur_ch    = $urandom_range(0, 3);
            cur_div   = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 4);
            cur_vol   = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) ch_enable = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 699) == 0);
            apply_stimulus();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
